// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared state encoding and constants for the pipeline hazard controller
package pipe_pkg;

  typedef enum logic [1:0] {
    ST_INIT     = 2'd0,
    ST_RUN      = 2'd1,
    ST_MEM_WAIT = 2'd2
  } state_e;

  localparam int REG_W    = 5;
  localparam int REG_ZERO = 0;
  localparam int INIT_CNT_W = 4;

endpackage

// File: rtl/pipe_hazard_ctrl_sat_counter.sv
// rtl/pipe_hazard_ctrl_sat_counter.sv - saturating event counter with synchronous clear
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk_i,
  input  logic         clear_i,
  input  logic         inc_i,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (inc_i && (cnt_q != {W{1'b1}})) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (clear_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// rtl/pipe_hazard_ctrl.sv - stall/flush sequencer for the 5-stage pipeline registers and PC
module pipe_hazard_ctrl #(
  parameter int INIT_BUBBLES = 2,
  parameter int CNT_W        = 16,
  parameter int REG_W        = pipe_pkg::REG_W
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_uses_rt,
  input  logic [REG_W-1:0] ex_rd,
  input  logic             ex_mem_read,
  input  logic             ex_branch_taken,
  input  logic             mem_busy,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             ifid_flush,
  output logic             idex_en,
  output logic             idex_flush,
  output logic             exmem_en,
  output logic             exmem_flush,
  output logic             memwb_en,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt,
  output logic             busy_init
);
  import pipe_pkg::*;

  localparam logic [INIT_CNT_W-1:0] INIT_LOAD = INIT_CNT_W'(INIT_BUBBLES - 1);

  state_e                  state_q, state_d;
  logic [INIT_CNT_W-1:0]   init_cnt_q, init_cnt_d;
  logic                    load_use;
  logic                    stall_inc;
  logic                    flush_inc;

  assign load_use = ex_mem_read && (ex_rd != REG_W'(REG_ZERO)) &&
                    ((ex_rd == id_rs) || (id_uses_rt && (ex_rd == id_rt)));

  always_comb begin
    state_d     = state_q;
    init_cnt_d  = init_cnt_q;
    pc_en       = 1'b1;
    ifid_en     = 1'b1;
    ifid_flush  = 1'b0;
    idex_en     = 1'b1;
    idex_flush  = 1'b0;
    exmem_en    = 1'b1;
    exmem_flush = 1'b0;
    memwb_en    = 1'b1;
    busy_init   = 1'b0;
    stall_inc   = 1'b0;
    flush_inc   = 1'b0;
    case (state_q)
      // A MEM_WAIT cycle with memory still busy is the same as RUN's top
      // priority case, so both states share one evaluation.
      ST_RUN, ST_MEM_WAIT: begin
        if (mem_busy) begin
          pc_en     = 1'b0;
          ifid_en   = 1'b0;
          idex_en   = 1'b0;
          exmem_en  = 1'b0;
          memwb_en  = 1'b0;
          stall_inc = 1'b1;
          state_d   = ST_MEM_WAIT;
        end else begin
          state_d = ST_RUN;
          if (ex_branch_taken) begin
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
            flush_inc  = 1'b1;
          end else if (load_use) begin
            pc_en      = 1'b0;
            ifid_en    = 1'b0;
            idex_flush = 1'b1;
            stall_inc  = 1'b1;
          end
        end
      end
      ST_INIT: begin
        pc_en       = 1'b0;
        ifid_flush  = 1'b1;
        idex_flush  = 1'b1;
        exmem_flush = 1'b1;
        busy_init   = 1'b1;
        if (init_cnt_q == '0) begin
          state_d = ST_RUN;
        end else begin
          init_cnt_d = init_cnt_q - INIT_CNT_W'(1);
        end
      end
      default: begin
        pc_en       = 1'b0;
        ifid_flush  = 1'b1;
        idex_flush  = 1'b1;
        exmem_flush = 1'b1;
        busy_init   = 1'b1;
        state_d     = ST_INIT;
        init_cnt_d  = INIT_LOAD;
      end
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q    <= ST_INIT;
      init_cnt_q <= INIT_LOAD;
    end else begin
      state_q    <= state_d;
      init_cnt_q <= init_cnt_d;
    end
  end

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk_i   (Clk),
    .clear_i (Rst),
    .inc_i   (stall_inc),
    .cnt_o   (stall_cnt)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk_i   (Clk),
    .clear_i (Rst),
    .inc_i   (flush_inc),
    .cnt_o   (flush_cnt)
  );

endmodule
